// File: rtl/aes_mix_columns_engine.sv
// aes_mix_columns_engine
// Handshaked AES MixColumns / InvMixColumns stage. One 128-bit state is
// accepted per transaction and LANES columns are transformed per clock.
// The inverse/forward mode is captured with the state at accept time.
module aes_mix_columns_engine #(
    parameter int unsigned  LANES       = 4,
    parameter logic [7:0]   REDUCE_POLY = 8'h1B,
    localparam int unsigned STATE_W     = 128
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic               in_inverse,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               busy
);

    localparam int unsigned NUM_COLS = 4;
    localparam int unsigned COL_W    = 32;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned CNT_W    = 2;
    localparam int unsigned SUM_W    = 3;

    // Only 1, 2 or 4 lanes divide the four columns evenly.
    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_lanes_check
        $fatal(1, "aes_mix_columns_engine: LANES must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_fsm;
    state_t           w_fsm_next;
    logic             w_accept;
    logic             w_calc;
    logic             w_last;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_mode;
    logic [CNT_W-1:0] r_col;

    logic [COL_W-1:0] w_in_cols  [NUM_COLS];
    logic [CNT_W-1:0] w_lane_idx [LANES];
    logic [COL_W-1:0] w_lane_out [LANES];

    // Multiply by x in GF(2^8), folding the overflow back with the reduction byte.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? REDUCE_POLY : 8'h00);
    endfunction

    // Transform one column; all constant multiples come from x2/x4/x8 chains.
    function automatic logic [COL_W-1:0] mix_col(input logic [COL_W-1:0] col,
                                                 input logic             inv);
        logic [BYTE_W-1:0] a  [4];
        logic [BYTE_W-1:0] x2 [4];
        logic [BYTE_W-1:0] x4 [4];
        logic [BYTE_W-1:0] x8 [4];
        logic [BYTE_W-1:0] m3 [4];
        logic [BYTE_W-1:0] m9 [4];
        logic [BYTE_W-1:0] mb [4];
        logic [BYTE_W-1:0] md [4];
        logic [BYTE_W-1:0] me [4];
        logic [BYTE_W-1:0] r  [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[BYTE_W*i +: BYTE_W];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m3[i] = x2[i] ^ a[i];
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        if (inv) begin
            r[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
            r[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
            r[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
            r[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
        end else begin
            r[0] = x2[0] ^ m3[1] ^ a[2]  ^ a[3];
            r[1] = a[0]  ^ x2[1] ^ m3[2] ^ a[3];
            r[2] = a[0]  ^ a[1]  ^ x2[2] ^ m3[3];
            r[3] = m3[0] ^ a[1]  ^ a[2]  ^ x2[3];
        end
        return {r[3], r[2], r[1], r[0]};
    endfunction

    // The final step is the one whose lanes reach column 3.
    assign w_last = (SUM_W'(r_col) + SUM_W'(LANES)) == SUM_W'(NUM_COLS);

    // Next-state decode and per-cycle strobes.
    always_comb begin
        w_fsm_next = r_fsm;
        w_accept   = 1'b0;
        w_calc     = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                if (in_valid && r_in_ready) begin
                    w_accept   = 1'b1;
                    w_fsm_next = S_CALC;
                end
            end
            S_CALC: begin
                w_calc = 1'b1;
                if (w_last) begin
                    w_fsm_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_fsm_next = S_IDLE;
                end
            end
            default: begin
                w_fsm_next = S_IDLE;
            end
        endcase
    end

    // State register with handshake/status outputs registered off the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_next;
            r_in_ready  <= (w_fsm_next == S_IDLE);
            r_out_valid <= (w_fsm_next == S_DONE);
            r_busy      <= (w_fsm_next != S_IDLE);
        end
    end

    // Column counter and captured mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col  <= '0;
            r_mode <= 1'b0;
        end else if (w_accept) begin
            r_col  <= '0;
            r_mode <= in_inverse;
        end else if (w_calc) begin
            r_col  <= r_col + CNT_W'(LANES);
        end
    end

    // One transform per lane, fed by the column mux at col + lane.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign w_lane_idx[l] = r_col + CNT_W'(l);
        assign w_lane_out[l] = mix_col(w_in_cols[w_lane_idx[l]], r_mode);
    end

    // Per-column input capture and result registers.
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        localparam int unsigned LANE  = c % LANES;
        localparam int unsigned START = (c / LANES) * LANES;

        logic [COL_W-1:0] r_in_col;
        logic [COL_W-1:0] r_out_col;
        logic             w_we;

        assign w_we = w_calc && (r_col == CNT_W'(START));

        // Hold the accepted column for the whole CALC phase.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_in_col <= '0;
            end else if (w_accept) begin
                r_in_col <= in_state[COL_W*c +: COL_W];
            end
        end

        // Write this column when its lane group is being computed.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_out_col <= '0;
            end else if (w_we) begin
                r_out_col <= w_lane_out[LANE];
            end
        end

        assign w_in_cols[c]               = r_in_col;
        assign out_state[COL_W*c +: COL_W] = r_out_col;
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_aes_mix_columns_engine.sv
// Bench for aes_mix_columns_engine: three instances (LANES 1, 2, 4), directed
// vectors, expected results queued at issue and checked by a monitor.
module tb_aes_mix_columns_engine;

    localparam int unsigned NDUT = 3;
    localparam logic [127:0] ST3  = {32'hC6C6C6C6, 32'h01010101, 32'h5C220AF2, 32'h455313DB};
    localparam logic [127:0] RES3 = {32'hC6C6C6C6, 32'h01010101, 32'h9D58DC9F, 32'hBCA14D8E};
    localparam logic [127:0] FIPS_IN  = {96'h0, 32'h455313DB};
    localparam logic [127:0] FIPS_OUT = {96'h0, 32'hBCA14D8E};

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid_a   [NDUT];
    logic         in_ready_a   [NDUT];
    logic [127:0] in_state_a   [NDUT];
    logic         in_inverse_a [NDUT];
    logic         out_valid_a  [NDUT];
    logic         out_ready_a  [NDUT];
    logic [127:0] out_state_a  [NDUT];
    logic         busy_a       [NDUT];

    int n_pass  = 0;
    int n_total = 0;

    logic [127:0] exp_val_q [$];
    bit           exp_chk_q [$];
    logic [1:0]   exp_dut_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        aes_mix_columns_engine #(
            .LANES      ((g == 0) ? 1 : ((g == 1) ? 2 : 4)),
            .REDUCE_POLY(8'h1B)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .in_state  (in_state_a[g]),
            .in_inverse(in_inverse_a[g]),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .out_state (out_state_a[g]),
            .busy      (busy_a[g])
        );
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    function automatic int lat_of(input logic [1:0] g);
        return (g == 2'd0) ? 4 : ((g == 2'd1) ? 2 : 1);
    endfunction

    task automatic expect_push(input logic [1:0] g, input bit chk, input logic [127:0] val);
        exp_val_q.push_back(val);
        exp_chk_q.push_back(chk);
        exp_dut_q.push_back(g);
    endtask

    // Pops one expectation for every completed output handshake.
    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int k = 0; k < int'(NDUT); k++) begin
                logic [1:0]   gi;
                logic [127:0] v;
                bit           c;
                logic [1:0]   d;
                gi = 2'(k);
                if (!rst && out_valid_a[gi] && out_ready_a[gi]) begin
                    if (exp_val_q.size() == 0) begin
                        n_total++;
                        $display("FAIL dut%0d unexpected_output: actual %h required none", k, out_state_a[gi]);
                    end else begin
                        v = exp_val_q.pop_front();
                        c = exp_chk_q.pop_front();
                        d = exp_dut_q.pop_front();
                        if (d != gi) begin
                            n_total++;
                            $display("FAIL dut%0d output_source: actual dut%0d required dut%0d", k, k, d);
                        end else if (c) begin
                            check($sformatf("dut%0d result", k), out_state_a[gi], v);
                        end
                    end
                end
            end
        end
    endtask

    task automatic send(input logic [1:0] g, input logic [127:0] st, input logic inv);
        int w;
        w = 0;
        in_state_a[g]   = st;
        in_inverse_a[g] = inv;
        in_valid_a[g]   = 1'b1;
        while (!in_ready_a[g] && w < 64) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 64) check($sformatf("dut%0d accept_timeout", g), 128'(in_ready_a[g]), 128'd1);
        @(posedge clk); #1;
        in_valid_a[g] = 1'b0;
    endtask

    task automatic wait_done(input logic [1:0] g, input bit toggle_mode, output int lat);
        lat = 0;
        while (!out_valid_a[g] && lat < 64) begin
            if (toggle_mode) in_inverse_a[g] = ~in_inverse_a[g];
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic xact(input logic [1:0] g, input logic [127:0] st, input logic inv,
                        input bit chk, input logic [127:0] exp, input bit toggle_mode,
                        output logic [127:0] got);
        int lat;
        expect_push(g, chk, exp);
        send(g, st, inv);
        wait_done(g, toggle_mode, lat);
        check($sformatf("dut%0d latency", g), 128'(lat), 128'(lat_of(g)));
        got = out_state_a[g];
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] y;
        logic [127:0] y2;
        logic [127:0] r;
        int           lat;

        rst = 1'b1;
        for (int k = 0; k < int'(NDUT); k++) begin
            in_valid_a[2'(k)]   = 1'b0;
            in_state_a[2'(k)]   = '0;
            in_inverse_a[2'(k)] = 1'b0;
            out_ready_a[2'(k)]  = 1'b1;
        end
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < int'(NDUT); k++) begin
            check($sformatf("dut%0d rst in_ready", k),  128'(in_ready_a[2'(k)]),  128'd1);
            check($sformatf("dut%0d rst out_valid", k), 128'(out_valid_a[2'(k)]), 128'd0);
            check($sformatf("dut%0d rst busy", k),      128'(busy_a[2'(k)]),      128'd0);
            check($sformatf("dut%0d rst out_state", k), out_state_a[2'(k)],       128'd0);
        end

        // FIPS-197 column, forward, LANES=4
        xact(2'd2, FIPS_IN, 1'b0, 1'b1, FIPS_OUT, 1'b0, y);

        // Inverse of the FIPS column and random round trip on every instance
        for (int k = 0; k < int'(NDUT); k++) begin
            xact(2'(k), FIPS_OUT, 1'b1, 1'b1, FIPS_IN, 1'b0, y);
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            xact(2'(k), r, 1'b0, 1'b0, '0, 1'b0, y);
            xact(2'(k), y, 1'b1, 1'b1, r, 1'b0, y2);
        end

        // Four distinct columns in one state, both directions
        for (int k = 0; k < int'(NDUT); k++) begin
            xact(2'(k), ST3, 1'b0, 1'b1, RES3, 1'b0, y);
            xact(2'(k), RES3, 1'b1, 1'b1, ST3, 1'b0, y);
        end

        // Backpressure on LANES=4 with a second request waiting
        out_ready_a[2] = 1'b0;
        expect_push(2'd2, 1'b1, RES3);
        send(2'd2, ST3, 1'b0);
        wait_done(2'd2, 1'b0, lat);
        check("dut2 bp latency", 128'(lat), 128'd1);
        expect_push(2'd2, 1'b1, FIPS_OUT);
        in_state_a[2]   = FIPS_IN;
        in_inverse_a[2] = 1'b0;
        in_valid_a[2]   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("dut2 bp hold out_state c%0d", i), out_state_a[2], RES3);
            check($sformatf("dut2 bp hold in_ready c%0d", i),  128'(in_ready_a[2]),  128'd0);
            check($sformatf("dut2 bp hold out_valid c%0d", i), 128'(out_valid_a[2]), 128'd1);
        end
        out_ready_a[2] = 1'b1;
        @(posedge clk); #1;
        check("dut2 bp release in_ready",  128'(in_ready_a[2]),  128'd1);
        check("dut2 bp release out_valid", 128'(out_valid_a[2]), 128'd0);
        @(posedge clk); #1;
        in_valid_a[2] = 1'b0;
        check("dut2 bp second accept busy",     128'(busy_a[2]),     128'd1);
        check("dut2 bp second accept in_ready", 128'(in_ready_a[2]), 128'd0);
        wait_done(2'd2, 1'b0, lat);
        check("dut2 bp second latency", 128'(lat), 128'd1);
        @(posedge clk); #1;

        // Reset during CALC on LANES=1 after two compute cycles
        send(2'd0, ST3, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("dut0 midcalc busy before rst", 128'(busy_a[0]), 128'd1);
        rst = 1'b1;
        #1;
        check("dut0 midrst out_valid", 128'(out_valid_a[0]), 128'd0);
        check("dut0 midrst out_state", out_state_a[0],       128'd0);
        check("dut0 midrst in_ready",  128'(in_ready_a[0]),  128'd1);
        check("dut0 midrst busy",      128'(busy_a[0]),      128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        xact(2'd0, ST3, 1'b0, 1'b1, RES3, 1'b0, y);

        // Mode toggling after accept must not affect the result
        for (int k = 0; k < 2; k++) begin
            xact(2'(k), ST3,  1'b0, 1'b1, RES3, 1'b1, y);
            xact(2'(k), RES3, 1'b1, 1'b1, ST3,  1'b1, y);
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard drained", 128'(exp_val_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
